// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - two-player key event FIFOs with round-robin drain
// into a single 4-phase ready/ack output register.

module kea_fifo #(
   parameter int CODE_W     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic              clk,
   input  logic              ar,
   input  logic              push_i,
   input  logic [CODE_W-1:0] data_i,
   input  logic              pop_i,
   input  logic              clr_i,
   output logic [CODE_W-1:0] head_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  level_o,
   output logic              ovf_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

   logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  level_q, level_d;
   logic              ovf_q, ovf_d;
   logic              full, push_ok;

   // Fullness is judged on the registered level, so a same-cycle pop never
   // makes room for an arriving event.
   assign full    = (level_q == FULL_LVL);
   assign push_ok = push_i & ~full;
   assign empty_o = (level_q == '0);
   assign head_o  = mem_q[rptr_q];
   assign level_o = level_q;
   assign ovf_o   = ovf_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_i)   rptr_d = rptr_q + AW'(1);
      case ({push_ok, pop_i})
         2'b10:   level_d = level_q + CNT_W'(1);
         2'b01:   level_d = level_q - CNT_W'(1);
         default: level_d = level_q;
      endcase
      ovf_d = (ovf_q & ~clr_i) | (push_i & full);
   end

   always_ff @(posedge clk or posedge ar) begin
      if (ar) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= data_i;
   end
endmodule

module key_event_arbiter #(
   parameter int CODE_W     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic              clk,
   input  logic              ar,
   input  logic [CODE_W-1:0] p0_code,
   input  logic              p0_valid,
   input  logic [CODE_W-1:0] p1_code,
   input  logic              p1_valid,
   input  logic              host_ack,
   input  logic              ovf_clr,
   output logic [CODE_W-1:0] out_code,
   output logic              out_src,
   output logic              out_rdy,
   output logic              p0_ovf,
   output logic              p1_ovf,
   output logic [CNT_W-1:0]  p0_level,
   output logic [CNT_W-1:0]  p1_level
);
   typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

   state_t            state_q, state_d;
   logic              ack_meta_q, ack_s_q;
   logic [CODE_W-1:0] code_q, code_d;
   logic              src_q, src_d;
   logic              rdy_q, rdy_d;
   logic              last_q, last_d;
   logic              pop0, pop1, gnt, gnt_src;
   logic [CODE_W-1:0] head0, head1;
   logic              empty0, empty1;

   kea_fifo #(.CODE_W(CODE_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_p0_fifo (
      .clk     (clk),
      .ar      (ar),
      .push_i  (p0_valid),
      .data_i  (p0_code),
      .pop_i   (pop0),
      .clr_i   (ovf_clr),
      .head_o  (head0),
      .empty_o (empty0),
      .level_o (p0_level),
      .ovf_o   (p0_ovf)
   );

   kea_fifo #(.CODE_W(CODE_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_p1_fifo (
      .clk     (clk),
      .ar      (ar),
      .push_i  (p1_valid),
      .data_i  (p1_code),
      .pop_i   (pop1),
      .clr_i   (ovf_clr),
      .head_o  (head1),
      .empty_o (empty1),
      .level_o (p1_level),
      .ovf_o   (p1_ovf)
   );

   always_ff @(posedge clk or posedge ar) begin
      if (ar) begin
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         ack_meta_q <= host_ack;
         ack_s_q    <= ack_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      src_d   = src_q;
      rdy_d   = rdy_q;
      last_d  = last_q;
      gnt     = 1'b0;
      gnt_src = 1'b0;
      pop0    = 1'b0;
      pop1    = 1'b0;
      case (state_q)
         IDLE: begin
            // A stale ack left high by the host blocks presentation.
            if (!ack_s_q && !(empty0 && empty1)) begin
               gnt = 1'b1;
               if (!empty0 && !empty1) gnt_src = ~last_q;
               else                    gnt_src = empty0;
               pop0    = ~gnt_src;
               pop1    = gnt_src;
               code_d  = gnt_src ? head1 : head0;
               src_d   = gnt_src;
               rdy_d   = 1'b1;
               last_d  = gnt_src;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (ack_s_q) begin
               rdy_d   = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            rdy_d = 1'b0;
            if (!ack_s_q) state_d = IDLE;
         end
         default: begin
            rdy_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge ar) begin
      if (ar) begin
         state_q <= IDLE;
         code_q  <= '0;
         src_q   <= 1'b0;
         rdy_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         src_q   <= src_d;
         rdy_q   <= rdy_d;
         last_q  <= last_d;
      end
   end

   assign out_code = code_q;
   assign out_src  = src_q;
   assign out_rdy  = rdy_q;
endmodule
